// File: rtl/jtroadf_pkg.sv
// Shared definitions for the Road Fighter main-to-sound bridge:
// timer defaults and the Z80 interrupt-acknowledge decode.
package jtroadf_pkg;

  // Default timer configuration: 512 sound clock enables per tick, 4-bit value.
  localparam int TIMER_DIV_DEF = 512;
  localparam int TIMER_W_DEF   = 4;

  // Z80 interrupt acknowledge is M1 and IORQ low together, packed as {m1_n, iorq_n}.
  localparam logic [1:0] Z80_INTACK = 2'b00;

  // True on a sound-clock-enabled interrupt acknowledge bus cycle.
  function automatic logic is_intack(input logic cen, input logic m1_n,
                                     input logic iorq_n);
    return cen && ({m1_n, iorq_n} == Z80_INTACK);
  endfunction

endpackage

// File: rtl/jtroadf_sndif_if.sv
// Main-CPU side bus into the sound bridge: bus-cycle enable, data,
// direction, latch select and the interrupt request level.
interface jtroadf_sndif_if;

  logic       cpu_cen;
  logic [7:0] main_dout;
  logic       main_rnw;
  logic       snd_data_cs;
  logic       snd_irq;

  // Main CPU decoder drives the bus.
  modport master (
    output cpu_cen, main_dout, main_rnw, snd_data_cs, snd_irq
  );

  // Sound bridge observes the bus.
  modport slave (
    input cpu_cen, main_dout, main_rnw, snd_data_cs, snd_irq
  );

endinterface

// File: rtl/jtroadf_snd_timer.sv
// Free-running sound timer: a power-of-two prescaler on snd_cen feeding a
// TIMER_W-bit wrapping counter that the sound CPU polls.
module jtroadf_snd_timer
  import jtroadf_pkg::*;
#(
  parameter int TIMER_DIV = TIMER_DIV_DEF,
  parameter int TIMER_W   = TIMER_W_DEF
) (
  input  logic               rst,
  input  logic               clk,
  input  logic               snd_cen,
  output logic [TIMER_W-1:0] timer
);

  localparam int PRE_W = $clog2(TIMER_DIV);

  logic [PRE_W-1:0]   pre_q, pre_d;
  logic [TIMER_W-1:0] cnt_q, cnt_d;
  logic               pre_wrap;

  // TIMER_DIV is a power of two, so the prescaler is at its last count when all ones.
  assign pre_wrap = &pre_q;

  // Next-state for prescaler and counter; both wrap naturally at their width.
  always_comb begin
    // NOTE: defaults first so every path assigns every _d signal and no latch is inferred.
    pre_d = pre_q;
    cnt_d = cnt_q;
    if (snd_cen) begin
      pre_d = pre_q + 1'b1;
      if (pre_wrap) cnt_d = cnt_q + 1'b1;
    end
  end

  // Timer state registers with synchronous reset.
  always_ff @(posedge clk) begin
    // NOTE: state uses non-blocking assignments so all flops update from pre-edge values.
    if (rst) begin
      pre_q <= '0;
      cnt_q <= '0;
    end else begin
      pre_q <= pre_d;
      cnt_q <= cnt_d;
    end
  end

  assign timer = cnt_q;

endmodule

// File: rtl/jtroadf_sndif.sv
// Road Fighter main-to-sound bridge: command latch, snd_irq edge to held
// Z80 INT (released by interrupt acknowledge), and the polled sound timer.
// Optional unread-command flag enabled with `define JTROADF_LATCH_FLAG_EN.
module jtroadf_sndif
  import jtroadf_pkg::*;
#(
  parameter int TIMER_DIV = TIMER_DIV_DEF,
  parameter int TIMER_W   = TIMER_W_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  jtroadf_sndif_if.slave        main,
  input  logic                  snd_cen,
  input  logic                  snd_m1_n,
  input  logic                  snd_iorq_n,
  input  logic                  latch_rd,
  output logic [7:0]            snd_latch,
  output logic                  snd_int_n,
  output logic [TIMER_W-1:0]    timer,
  output logic                  latch_full
);

  logic [7:0] latch_q, latch_d;
  logic       irq_l_q, irq_l_d;
  logic       int_n_q, int_n_d;
  logic       latch_wr;
  logic       irq_set;
  logic       irq_ack;

  assign latch_wr = main.cpu_cen & main.snd_data_cs & ~main.main_rnw;
  assign irq_set  = main.cpu_cen & main.snd_irq & ~irq_l_q;
  assign irq_ack  = is_intack(snd_cen, snd_m1_n, snd_iorq_n);

  // Command latch, irq edge register and INT hold; a new edge beats a same-cycle ack.
  always_comb begin
    latch_d = latch_q;
    irq_l_d = irq_l_q;
    int_n_d = int_n_q;
    if (latch_wr)          latch_d = main.main_dout;
    if (main.cpu_cen)      irq_l_d = main.snd_irq;
    if (irq_set)           int_n_d = 1'b0;
    else if (irq_ack)      int_n_d = 1'b1;
  end

  // Bridge state registers; reset overrides any same-cycle write, edge or ack.
  always_ff @(posedge clk) begin
    if (rst) begin
      latch_q <= 8'h00;
      irq_l_q <= 1'b0;
      int_n_q <= 1'b1;
    end else begin
      latch_q <= latch_d;
      irq_l_q <= irq_l_d;
      int_n_q <= int_n_d;
    end
  end

  assign snd_latch = latch_q;
  assign snd_int_n = int_n_q;

`ifdef JTROADF_LATCH_FLAG_EN
  logic full_q, full_d;

  // Unread flag: set on write, cleared on sound-side read; write wins a collision.
  always_comb begin
    full_d = full_q;
    if (snd_cen && latch_rd) full_d = 1'b0;
    if (latch_wr)            full_d = 1'b1;
  end

  // Flag register.
  always_ff @(posedge clk) begin
    if (rst) full_q <= 1'b0;
    else     full_q <= full_d;
  end

  assign latch_full = full_q;
`else
  logic unused_latch_rd;

  assign unused_latch_rd = latch_rd;
  assign latch_full      = 1'b0;
`endif

  jtroadf_snd_timer #(
    .TIMER_DIV (TIMER_DIV),
    .TIMER_W   (TIMER_W)
  ) u_timer (
    .rst     (rst),
    .clk     (clk),
    .snd_cen (snd_cen),
    .timer   (timer)
  );

endmodule

// File: tb/tb_jtroadf_sndif.sv
// Self-checking bench for jtroadf_sndif: directed vector table, hand
// sequences for timer/irq/flag corners, and a randomized run against a
// behavioural model kept in terms of event counts.
module tb_jtroadf_sndif;

  localparam int TDIV = 512;
  localparam int TW   = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          snd_cen, snd_m1_n, snd_iorq_n, latch_rd;
  logic [7:0]    snd_latch;
  logic          snd_int_n;
  logic [TW-1:0] timer;
  logic          latch_full;

  jtroadf_sndif_if bus ();

  jtroadf_sndif #(.TIMER_DIV(TDIV), .TIMER_W(TW)) dut (
    .clk        (clk),
    .rst        (rst),
    .main       (bus),
    .snd_cen    (snd_cen),
    .snd_m1_n   (snd_m1_n),
    .snd_iorq_n (snd_iorq_n),
    .latch_rd   (latch_rd),
    .snd_latch  (snd_latch),
    .snd_int_n  (snd_int_n),
    .timer      (timer),
    .latch_full (latch_full)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Behavioural model: timer is derived from the total snd_cen count since reset.
  logic [7:0] m_latch;
  logic       m_int_n;
  logic       m_irq_l;
  logic       m_full;
  int         m_pulses;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int exp_timer();
    return (m_pulses / TDIV) % (1 << TW);
  endfunction

  task automatic model_update();
    logic wr, set, ack;
    if (rst) begin
      m_latch = 8'h00; m_int_n = 1'b1; m_irq_l = 1'b0; m_full = 1'b0; m_pulses = 0;
    end else begin
      wr  = bus.cpu_cen && bus.snd_data_cs && !bus.main_rnw;
      set = bus.cpu_cen && bus.snd_irq && !m_irq_l;
      ack = snd_cen && !snd_m1_n && !snd_iorq_n;
      if (wr) m_latch = bus.main_dout;
      if (set) m_int_n = 1'b0;
      else if (ack) m_int_n = 1'b1;
      if (bus.cpu_cen) m_irq_l = bus.snd_irq;
      if (snd_cen) m_pulses++;
`ifdef JTROADF_LATCH_FLAG_EN
      if (wr) m_full = 1'b1;
      else if (snd_cen && latch_rd) m_full = 1'b0;
`endif
    end
  endtask

  // One clock: model consumes the inputs sampled at the edge, outputs settle by #1.
  task automatic tick();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic check_all(input string tag);
    check({tag, " latch"}, 32'(snd_latch), 32'(m_latch));
    check({tag, " int_n"}, 32'(snd_int_n), 32'(m_int_n));
    check({tag, " timer"}, 32'(timer), 32'(exp_timer()));
    check({tag, " full"},  32'(latch_full), 32'(m_full));
  endtask

  task automatic idle();
    rst = 1'b0; bus.cpu_cen = 1'b0; bus.main_dout = 8'h00; bus.main_rnw = 1'b1;
    bus.snd_data_cs = 1'b0; snd_cen = 1'b0; snd_m1_n = 1'b1; snd_iorq_n = 1'b1;
    latch_rd = 1'b0;
  endtask

  task automatic mwrite(input logic [7:0] d);
    bus.cpu_cen = 1'b1; bus.snd_data_cs = 1'b1; bus.main_rnw = 1'b0; bus.main_dout = d;
  endtask

  typedef struct {
    logic       rst, cen;
    logic [7:0] dout;
    logic       rnw, cs, irq, scen, m1_n, iorq_n;
    logic [7:0] e_latch;
    logic       e_int_n;
  } vec_t;

  vec_t vecs[16];

  initial begin
    int last_change, prev_t;

    vecs[0]  = '{1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 8'h00, 1'b1}; // reset
    vecs[1]  = '{1'b0, 1'b1, 8'hA5, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 8'hA5, 1'b1}; // write
    vecs[2]  = '{1'b0, 1'b0, 8'h77, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 8'hA5, 1'b1}; // cs, no cen
    vecs[3]  = '{1'b0, 1'b1, 8'h3C, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 8'hA5, 1'b1}; // read cycle
    vecs[4]  = '{1'b0, 1'b1, 8'h5A, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 8'h5A, 1'b1}; // back-to-back
    vecs[5]  = '{1'b0, 1'b1, 8'hC3, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 8'hC3, 1'b1};
    vecs[6]  = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 8'hC3, 1'b1}; // irq, no cen
    vecs[7]  = '{1'b0, 1'b1, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 8'hC3, 1'b0}; // irq edge
    vecs[8]  = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'hC3, 1'b0}; // ack w/o snd_cen
    vecs[9]  = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 8'hC3, 1'b0}; // m1 only
    vecs[10] = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'hC3, 1'b1}; // ack
    vecs[11] = '{1'b0, 1'b1, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 8'hC3, 1'b1}; // held high
    vecs[12] = '{1'b0, 1'b1, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 8'hC3, 1'b1}; // irq low
    vecs[13] = '{1'b0, 1'b1, 8'h00, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'hC3, 1'b0}; // set+ack
    vecs[14] = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'hC3, 1'b1}; // ack alone
    vecs[15] = '{1'b1, 1'b1, 8'h99, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 1'b1}; // reset wins

    idle();
    bus.snd_irq = 1'b0;
    rst = 1'b1;

    // Directed vector table.
    for (int i = 0; i < 16; i++) begin
      rst = vecs[i].rst; bus.cpu_cen = vecs[i].cen; bus.main_dout = vecs[i].dout;
      bus.main_rnw = vecs[i].rnw; bus.snd_data_cs = vecs[i].cs; bus.snd_irq = vecs[i].irq;
      snd_cen = vecs[i].scen; snd_m1_n = vecs[i].m1_n; snd_iorq_n = vecs[i].iorq_n;
      latch_rd = 1'b0;
      tick();
      check($sformatf("vec%0d latch", i), 32'(snd_latch), 32'(vecs[i].e_latch));
      check($sformatf("vec%0d int_n", i), 32'(snd_int_n), 32'(vecs[i].e_int_n));
      if (vecs[i].rst) begin
        check($sformatf("vec%0d timer", i), 32'(timer), 32'd0);
        check($sformatf("vec%0d full", i), 32'(latch_full), 32'd0);
      end
    end

    // Held irq level over 10 cpu_cen: INT stays asserted, then ack, then no retrigger.
    idle();
    bus.snd_irq = 1'b1; bus.cpu_cen = 1'b1;
    tick();
    check("held edge int_n", 32'(snd_int_n), 32'd0);
    for (int i = 0; i < 10; i++) begin
      tick();
      check("held high int_n", 32'(snd_int_n), 32'd0);
    end
    bus.cpu_cen = 1'b0; snd_cen = 1'b1; snd_m1_n = 1'b0; snd_iorq_n = 1'b0;
    tick();
    check("held ack int_n", 32'(snd_int_n), 32'd1);
    idle();
    bus.cpu_cen = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      check("no retrigger int_n", 32'(snd_int_n), 32'd1);
    end

    // Full timer sweep: 512 snd_cen pulses per step, 16 steps back to zero.
    idle();
    bus.snd_irq = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0; snd_cen = 1'b1;
    last_change = 0; prev_t = 0;
    for (int p = 1; p <= TDIV * 16; p++) begin
      tick();
      check("sweep timer", 32'(timer), 32'(exp_timer()));
      if (int'(timer) != prev_t) begin
        check("step spacing", 32'(p - last_change), 32'(TDIV));
        check("step value", 32'(timer), 32'((prev_t + 1) % 16));
        last_change = p;
        prev_t = int'(timer);
      end
    end
    check("sweep wrap", 32'(timer), 32'd0);

    // Reset mid-count clears timer and prescaler.
    for (int p = 0; p < 700; p++) tick();
    check("midcount timer", 32'(timer), 32'd1);
    rst = 1'b1;
    tick();
    check("midcount rst timer", 32'(timer), 32'd0);
    rst = 1'b0;
    for (int p = 0; p < TDIV - 1; p++) tick();
    check("post rst 511", 32'(timer), 32'd0);
    tick();
    check("post rst 512", 32'(timer), 32'd1);

`ifdef JTROADF_LATCH_FLAG_EN
    // Unread flag corners.
    idle();
    mwrite(8'h01);
    tick();
    check("flag set", 32'(latch_full), 32'd1);
    idle();
    latch_rd = 1'b1;
    tick();
    check("flag rd w/o cen", 32'(latch_full), 32'd1);
    snd_cen = 1'b1;
    tick();
    check("flag cleared", 32'(latch_full), 32'd0);
    mwrite(8'h02);
    tick();
    check("flag wr+rd", 32'(latch_full), 32'd1);
    check("flag wr+rd latch", 32'(snd_latch), 32'h02);
`else
    idle();
    mwrite(8'h01);
    latch_rd = 1'b1;
    tick();
    check("flag absent", 32'(latch_full), 32'd0);
`endif

    // Randomized run against the model.
    for (int i = 0; i < 3000; i++) begin
      rst             = ($urandom_range(0, 199) == 0);
      bus.cpu_cen     = $urandom_range(0, 1) == 1;
      bus.main_dout   = 8'($urandom);
      bus.main_rnw    = $urandom_range(0, 1) == 1;
      bus.snd_data_cs = $urandom_range(0, 3) == 0;
      if ($urandom_range(0, 7) == 0) bus.snd_irq = ~bus.snd_irq;
      snd_cen         = $urandom_range(0, 1) == 1;
      if ($urandom_range(0, 9) == 0) begin
        snd_m1_n = 1'b0; snd_iorq_n = 1'b0;
      end else begin
        snd_m1_n = $urandom_range(0, 1) == 1; snd_iorq_n = 1'b1;
      end
      latch_rd        = $urandom_range(0, 3) == 0;
      tick();
      check_all("rand");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/jtroadf_sndif.md
Name: jtroadf_sndif

Overview:
- Main-to-sound bridge for the Road Fighter core, directly downstream of the main CPU decoder.
- Captures the main-CPU sound command byte into a latch.
- Converts the main CPU's snd_irq level into a held Z80 interrupt, released by the Z80 interrupt-acknowledge cycle.
- Provides the free-running sound timer that the sound CPU polls.

Parameters:
- TIMER_DIV, 512: snd_cen pulses per timer increment (power of two, ≥2).
- TIMER_W, 4: width of the readable timer value.

Ports:
- clk  in  1  system clock, 24 MHz
- rst  in  1  synchronous, active-high reset
- cpu_cen  in  1  main CPU bus-cycle enable (Q clock)
- main_dout  in  8  main CPU data bus
- main_rnw  in  1  main CPU read/not-write
- snd_data_cs  in  1  main-side sound latch select
- snd_irq  in  1  main-side interrupt request level
- snd_cen  in  1  sound CPU clock enable
- snd_m1_n  in  1  Z80 M1, active low
- snd_iorq_n  in  1  Z80 IORQ, active low
- latch_rd  in  1  sound-side latch read strobe; valid when qualified by snd_cen
- snd_latch  out  8  latched command byte
- snd_int_n  out  1  Z80 INT, active low
- timer  out  TIMER_W  timer value
- latch_full  out  1  unread-command flag (optional feature)

Behaviour:
- Reset values: snd_latch=0, snd_int_n=1, timer=0, latch_full=0. Reset also clears the prescaler and the snd_irq edge register.
- Reset mid-operation: reset wins over every event in the same cycle.
- Latch write: on a clk edge where cpu_cen & snd_data_cs & ~main_rnw, load snd_latch<=main_dout.
  - Visible on the next clk.
  - No write occurs when cpu_cen=0, even with cs held.
  - Back-to-back writes overwrite the latch; no queueing.
- IRQ edge detect:
  - irq_l<=snd_irq, sampled only when cpu_cen=1.
  - snd_irq & ~irq_l with cpu_cen=1 sets pending; snd_int_n<=0 on the next clk.
  - A level held high does not re-trigger.
- IRQ acknowledge: on snd_cen & ~snd_m1_n & ~snd_iorq_n, clear pending; snd_int_n<=1 on the next clk.
- Simultaneous set and acknowledge in one clk: set wins, so snd_int_n stays 0.
- Timer:
  - A prescaler of log2(TIMER_DIV) bits increments on each snd_cen.
  - When the prescaler is at TIMER_DIV-1 and snd_cen=1, it wraps to 0 and timer increments.
  - timer wraps from 2^TIMER_W-1 to 0.
  - timer is a registered output, 0 clk latency after the increment edge.
- No combinational path from any input to any output.

Optional Feature:
- Macro: JTROADF_LATCH_FLAG_EN.
- Defined:
  - latch_full is set on a latch write and cleared on snd_cen & latch_rd.
  - A write and a read in the same clk leave latch_full=1.
- Undefined: latch_full is constant 0, latch_rd is ignored, and no flag flop is built.

Decomposition:
- Shared package jtroadf_pkg holds the defaults for TIMER_DIV and TIMER_W and the Z80 acknowledge-decode constant.
- The timer is a natural sub-module, jtroadf_snd_timer, with ports (rst, clk, snd_cen, timer), parameterised by TIMER_DIV and TIMER_W.
- Latch and IRQ logic stay in the top module.

Test Plan:
- Write: cpu_cen pulse with snd_data_cs=1, main_rnw=0, main_dout=8'hA5 -> snd_latch=8'hA5 one clk later.
- Read cycle: repeat with main_rnw=1, main_dout=8'h3C -> snd_latch stays 8'hA5.
- IRQ set and ack: snd_irq 0→1 sampled on cpu_cen -> snd_int_n=0 next clk.
  - snd_irq held high for 10 cpu_cen -> no change.
  - Ack with m1_n=0, iorq_n=0, snd_cen=1 -> snd_int_n=1.
- Set/ack collision: new snd_irq edge in the same clk as the ack -> snd_int_n remains 0.
- Timer: TIMER_DIV=512, 512×16 snd_cen pulses -> timer steps 0..15, returns to 0, with exactly 512 pulses between steps. Assert rst mid-count -> timer=0 next clk.
- Flag (macro defined): write 8'h01 -> latch_full=1; latch_rd with snd_cen -> 0; write and read in the same clk -> 1.
